// File: rtl/mole_spawner_if.sv
// Handshake bundle between the mole spawner and the mole array.
// The spawner is the master: it consumes game/hiding status and issues go requests.
interface mole_spawner_if;
  logic       enable;
  logic [1:0] level;
  logic [7:0] hiding;
  logic [7:0] control;
  logic [15:0] spawn_count;
  logic       timeout;
  logic       busy;

  modport master (
    input  enable,
    input  level,
    input  hiding,
    output control,
    output spawn_count,
    output timeout,
    output busy
  );

  modport slave (
    output enable,
    output level,
    output hiding,
    input  control,
    input  spawn_count,
    input  timeout,
    input  busy
  );
endinterface

// File: rtl/mole_spawner.sv
// LFSR-paced go-request generator for the mole array: picks a hiding mole each
// interval and holds its go bit until the mole rises (ack) or a timeout expires.
module mole_spawner #(
  parameter int unsigned BASE_INTERVAL = 25000000,
  parameter int unsigned MAX_ACTIVE    = 3,
  parameter int unsigned ACK_TIMEOUT   = 1000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic           clock,
  input  logic           reset,
  mole_spawner_if.master bus
);

  localparam int unsigned CNT_W = (BASE_INTERVAL > 2) ? $clog2(BASE_INTERVAL) : 1;
  localparam int unsigned TMR_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  // An all-zero seed would lock the LFSR, so it is replaced with 1.
  localparam logic [15:0]      SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [3:0]       MAX_V    = 4'(MAX_ACTIVE);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    PICK,
    ISSUE
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       probe_q, probe_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [7:0]       control_q, control_d;
  logic [15:0]      count_q, count_d;
  logic             timeout_q, timeout_d;

  logic [3:0]       active;
  logic [CNT_W-1:0] reload;
  logic             lfsr_fb;

  function automatic logic [CNT_W-1:0] reload_value(input logic [1:0] lvl);
    return CNT_W'((BASE_INTERVAL >> lvl) - 1);
  endfunction

  always_comb begin
    active = '0;
    for (int i = 0; i < 8; i++) begin
      active = active + {3'b000, ~bus.hiding[i]};
    end
  end

  assign reload  = reload_value(bus.level);
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_comb begin
    state_d   = state_q;
    lfsr_d    = {lfsr_q[14:0], lfsr_fb};
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    probe_d   = probe_q;
    tmr_d     = tmr_q;
    control_d = control_q;
    count_d   = count_q;
    timeout_d = 1'b0;

    if (!bus.enable) begin
      state_d   = IDLE;
      cnt_d     = '0;
      idx_d     = '0;
      probe_d   = '0;
      tmr_d     = '0;
      control_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          control_d = '0;
          state_d   = WAIT;
          cnt_d     = reload;
        end

        WAIT: begin
          // At zero the counter parks until the active-mole cap frees up.
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (active < MAX_V) begin
            state_d = PICK;
            idx_d   = lfsr_q[2:0];
            probe_d = '0;
          end
        end

        PICK: begin
          if (bus.hiding[idx_q]) begin
            state_d   = ISSUE;
            control_d = 8'd1 << idx_q;
            tmr_d     = '0;
          end else if (probe_q == 3'd7) begin
            state_d = WAIT;
            cnt_d   = reload;
          end else begin
            idx_d   = idx_q + 3'd1;
            probe_d = probe_q + 3'd1;
          end
        end

        ISSUE: begin
          // Ack is tested first so it wins over a simultaneous timeout.
          if (!bus.hiding[idx_q]) begin
            control_d = '0;
            count_d   = count_q + 16'd1;
            state_d   = WAIT;
            cnt_d     = reload;
          end else if (tmr_q == TMR_LAST) begin
            control_d = '0;
            timeout_d = 1'b1;
            state_d   = WAIT;
            cnt_d     = reload;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end

        default: begin
          state_d   = IDLE;
          control_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED;
      cnt_q     <= '0;
      idx_q     <= '0;
      probe_q   <= '0;
      tmr_q     <= '0;
      control_q <= '0;
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      probe_q   <= probe_d;
      tmr_q     <= tmr_d;
      control_q <= control_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.control     = control_q;
  assign bus.spawn_count = count_q;
  assign bus.timeout     = timeout_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mole_spawner.sv
// Bench for mole_spawner: two configurations checked every cycle against a
// behavioural model, plus directed timing, cap, timeout, reset and probe-exhaustion cases.
module tb_mole_spawner;

  localparam int M_IDLE  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_PICK  = 2;
  localparam int M_ISSUE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [1:0] lvl = 2'd0;
  logic [7:0] hid [2];

  int n_tests = 0;
  int n_fail  = 0;

  mole_spawner_if ifa ();
  mole_spawner_if ifb ();

  assign ifa.enable = en;
  assign ifa.level  = lvl;
  assign ifa.hiding = hid[0];
  assign ifb.enable = en;
  assign ifb.level  = lvl;
  assign ifb.hiding = hid[1];

  mole_spawner #(
    .BASE_INTERVAL(16),
    .MAX_ACTIVE   (3),
    .ACK_TIMEOUT  (8),
    .LFSR_SEED    (16'hACE1)
  ) u_dut_a (
    .clock(clk),
    .reset(rst),
    .bus  (ifa.master)
  );

  mole_spawner #(
    .BASE_INTERVAL(8),
    .MAX_ACTIVE   (8),
    .ACK_TIMEOUT  (8),
    .LFSR_SEED    (16'h0000)
  ) u_dut_b (
    .clock(clk),
    .reset(rst),
    .bus  (ifb.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          ph     [2];
  int          wt     [2];
  int          pidx   [2];
  int          nprobe [2];
  int          tmr    [2];
  logic [7:0]  m_ctrl [2];
  logic [15:0] m_cnt  [2];
  bit          m_to   [2];
  logic [15:0] m_lf   [2];
  int          p_base [2] = '{16, 8};
  int          p_max  [2] = '{3, 8};
  int          p_tmo  [2] = '{8, 8};
  logic [15:0] p_seed [2] = '{16'hACE1, 16'h0001};

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] fb;
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 16'h0001;
    return (v << 1) | fb;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ph[k] = M_IDLE; wt[k] = 0; pidx[k] = 0; nprobe[k] = 0; tmr[k] = 0;
      m_ctrl[k] = 8'h00; m_cnt[k] = 16'h0000; m_to[k] = 1'b0; m_lf[k] = p_seed[k];
    end
  endtask

  task automatic model_step(input int k);
    int act;
    int rl;
    act = $countones(~hid[k]);
    rl  = (p_base[k] >> lvl) - 1;
    m_to[k] = 1'b0;
    if (!en) begin
      ph[k] = M_IDLE; wt[k] = 0; m_ctrl[k] = 8'h00;
    end else begin
      case (ph[k])
        M_IDLE: begin ph[k] = M_WAIT; wt[k] = rl; end
        M_WAIT: begin
          if (wt[k] > 0) wt[k] = wt[k] - 1;
          else if (act < p_max[k]) begin
            ph[k] = M_PICK; pidx[k] = int'(m_lf[k] % 16'd8); nprobe[k] = 0;
          end
        end
        M_PICK: begin
          if (hid[k][pidx[k]]) begin
            ph[k] = M_ISSUE; m_ctrl[k] = 8'h01 << pidx[k]; tmr[k] = 0;
          end else if (nprobe[k] == 7) begin
            ph[k] = M_WAIT; wt[k] = rl;
          end else begin
            pidx[k] = (pidx[k] + 1) % 8; nprobe[k] = nprobe[k] + 1;
          end
        end
        default: begin
          if (!hid[k][pidx[k]]) begin
            m_cnt[k] = m_cnt[k] + 16'd1; m_ctrl[k] = 8'h00; ph[k] = M_WAIT; wt[k] = rl;
          end else if (tmr[k] == p_tmo[k] - 1) begin
            m_ctrl[k] = 8'h00; m_to[k] = 1'b1; ph[k] = M_WAIT; wt[k] = rl;
          end else begin
            tmr[k] = tmr[k] + 1;
          end
        end
      endcase
    end
    m_lf[k] = lfsr_step(m_lf[k]);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  // Per-cycle comparison of both DUTs against the model, away from the clock edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("ctrl_a", ifa.control, m_ctrl[0]);
      check("cnt_a", ifa.spawn_count, m_cnt[0]);
      check("to_a", ifa.timeout, m_to[0]);
      check("busy_a", ifa.busy, ph[0] != M_IDLE);
      check("ctrl_b", ifb.control, m_ctrl[1]);
      check("cnt_b", ifb.spawn_count, m_cnt[1]);
      check("to_b", ifb.timeout, m_to[1]);
      check("busy_b", ifb.busy, ph[1] != M_IDLE);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_ctrl_a(input int limit, output int n);
    bit found;
    found = 1'b0;
    n = 0;
    while (n < limit && !found) begin
      @(posedge clk);
      #1;
      n++;
      if (ifa.control != 8'h00) found = 1'b1;
    end
    if (!found) n = -1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int          n;
    logic [7:0]  tgt;
    bit          seen;
    bit          to_seen;
    int          high;
    hid[0] = 8'hFF;
    hid[1] = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", ifa.control, 8'h00);
    check("rst_cnt", ifa.spawn_count, 16'h0000);
    check("rst_to", ifa.timeout, 1'b0);
    check("rst_busy", ifa.busy, 1'b0);

    // First spawn timing: interval 16, level 0 -> control on the 18th edge.
    @(negedge clk);
    #1 rst = 1'b0;
    en = 1'b1;
    wait_ctrl_a(100, n);
    check("first_spawn_edges", n, 18);
    check("first_spawn_onehot", $countones(ifa.control), 1);
    tgt = ifa.control;
    repeat (2) @(posedge clk);
    #1 hid[0] = hid[0] & ~tgt;
    @(posedge clk);
    #1;
    check("ack_ctrl_clear", ifa.control, 8'h00);
    check("ack_count", ifa.spawn_count, 16'd1);
    check("ack_no_timeout", ifa.timeout, 1'b0);

    // Level scaling: 16 >> 3 = 2 cycles -> control on the 4th edge.
    pulse_reset();
    lvl = 2'd3;
    hid[0] = 8'hFF;
    en = 1'b1;
    wait_ctrl_a(100, n);
    check("level3_edges", n, 4);

    // Active cap: three moles out with MAX_ACTIVE = 3 stalls spawning.
    pulse_reset();
    lvl = 2'd0;
    hid[0] = 8'hF8;
    en = 1'b1;
    seen = 1'b0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (ifa.control != 8'h00) seen = 1'b1;
    end
    check("cap_stall", seen, 1'b0);
    check("cap_busy", ifa.busy, 1'b1);
    hid[0] = 8'hF9;
    wait_ctrl_a(12, n);
    check("cap_release", n > 0, 1'b1);
    check("cap_target_hiding", ifa.control & ~hid[0], 8'h00);

    // Timeout: go held 8 cycles, one-cycle timeout pulse, count untouched.
    pulse_reset();
    hid[0] = 8'hFF;
    en = 1'b1;
    wait_ctrl_a(40, n);
    check("to_issue_found", n > 0, 1'b1);
    high = 1;
    to_seen = 1'b0;
    while (ifa.control != 8'h00 && high < 50) begin
      @(posedge clk);
      #1;
      if (ifa.control != 8'h00) high++;
      else to_seen = ifa.timeout;
    end
    check("timeout_hold", high, 8);
    check("timeout_pulse", to_seen, 1'b1);
    check("timeout_count", ifa.spawn_count, 16'h0000);
    @(posedge clk);
    #1;
    check("timeout_one_cycle", ifa.timeout, 1'b0);

    // Ack arriving on the timeout cycle wins.
    wait_ctrl_a(40, n);
    check("late_issue_found", n > 0, 1'b1);
    tgt = ifa.control;
    repeat (7) @(posedge clk);
    #1 hid[0] = hid[0] & ~tgt;
    @(posedge clk);
    #1;
    check("late_ack_ctrl", ifa.control, 8'h00);
    check("late_ack_no_to", ifa.timeout, 1'b0);
    check("late_ack_count", ifa.spawn_count, 16'd1);

    // Async reset in the middle of ISSUE drops control without a clock edge.
    hid[0] = 8'hFF;
    wait_ctrl_a(40, n);
    check("rst_issue_found", n > 0, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ctrl", ifa.control, 8'h00);
    check("async_rst_busy", ifa.busy, 1'b0);
    check("async_rst_cnt", ifa.spawn_count, 16'h0000);
    en = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;

    // Probe exhaustion on B: everything goes out just after PICK is entered.
    hid[1] = 8'h80;
    en = 1'b1;
    n = 0;
    while (ph[1] != M_PICK && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("exhaust_pick_reached", ph[1] == M_PICK, 1'b1);
    hid[1] = 8'h00;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (ifb.control != 8'h00 || ifb.timeout) seen = 1'b1;
    end
    check("exhaust_quiet", seen, 1'b0);
    check("exhaust_busy", ifb.busy, 1'b1);

    // Randomized phase: mole environment reacts to the model's go vector.
    pulse_reset();
    hid[0] = 8'hFF;
    hid[1] = 8'hFF;
    en = 1'b1;
    repeat (3000) begin
      @(negedge clk);
      if (en && $urandom_range(0, 299) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 5) == 0) en = 1'b1;
      if ($urandom_range(0, 79) == 0) lvl = 2'($urandom_range(0, 3));
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 8; i++) begin
          if (m_ctrl[k][i] && hid[k][i]) begin
            if ($urandom_range(0, 4) == 0) hid[k][i] = 1'b0;
          end else if (!hid[k][i]) begin
            if ($urandom_range(0, 7) == 0) hid[k][i] = 1'b1;
          end else if ($urandom_range(0, 99) == 0) begin
            hid[k][i] = 1'b0;
          end
        end
      end
      if ($urandom_range(0, 149) == 0) hid[1] = 8'h00;
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mole_spawner.md
Name: mole_spawner

Overview:
- Upstream stage of the mole-count block: generates the 8-bit per-mole `control` (go) vector that starts each mole's rise.
- Uses a free-running 16-bit LFSR to pick moles pseudo-randomly, paced by a level-dependent interval.
- Only targets moles currently reporting `hiding`, and caps the number of simultaneously exposed moles.
- Holds each go request until the target mole leaves hiding, which acts as the acknowledge, or until a timeout expires.

Parameters:
- BASE_INTERVAL, 25000000, spawn spacing in clock cycles at level 0; must be at least 8.
- MAX_ACTIVE, 3, maximum moles allowed out of hiding (range 1..8) before spawning stalls.
- ACK_TIMEOUT, 1000, cycles a go request is held without acknowledge before being abandoned.
- LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.

Ports:
- clock  input  1  system clock (50 MHz).
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  game running; low forces the IDLE state.
- level  input  2  speed level; effective interval = BASE_INTERVAL >> level.
- hiding  input  8  per-mole hiding status from the mole FSMs; 1 = mole down.
- control  output  8  registered go vector to the moles; one-hot or zero.
- spawn_count  output  16  binary count of acknowledged spawns; wraps 16'hFFFF -> 0.
- timeout  output  1  one-cycle pulse when a go request is abandoned.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Reset (async, active-high):
  - control = 0, spawn_count = 0, timeout = 0, busy = 0.
  - state = IDLE, LFSR = seed, interval counter = 0.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Shifts every clock edge regardless of state; never reaches 0.
- active = popcount(~hiding), evaluated combinationally each cycle.
- State IDLE:
  - control = 0.
  - enable = 1 -> WAIT, interval counter loaded with (BASE_INTERVAL >> level) - 1.
- State WAIT:
  - Counter decrements once per cycle.
  - Counter = 0 and active < MAX_ACTIVE -> PICK, probe idx = LFSR[2:0], probe count = 0.
  - Counter = 0 and active >= MAX_ACTIVE -> stay in WAIT with counter at 0 and re-check every cycle. No reload, no spawn.
- State PICK (one probe per cycle):
  - hiding[idx] = 1 -> ISSUE. Register idx; control = 1 << idx, visible the edge PICK is left. Ack timer = 0.
  - Otherwise idx = (idx + 1) mod 8 and probe count increments.
  - After 8 failed probes -> WAIT with reload. Nothing is issued; timeout is not pulsed.
- State ISSUE:
  - control held at 1 << idx.
  - hiding[idx] = 0 (ack): control = 0 and spawn_count += 1 at that edge -> WAIT with reload.
  - Otherwise the ack timer increments.
  - Timer reaches ACK_TIMEOUT - 1 without ack: control = 0, timeout = 1 for one cycle -> WAIT with reload.
  - Ack and timeout in the same cycle: the ack wins (count increments, no timeout pulse).
- enable = 0 in any state: next edge -> IDLE, control = 0, counters cleared. spawn_count is held.
- level is sampled only at counter reload; a change mid-interval takes effect at the next reload.
- control is never multi-hot and never asserted for a mole with hiding = 0 at PICK time.
- Async reset mid-ISSUE drops control the same instant, with no clock edge needed.
- Latency from enable sampled high to first control assertion, assuming the first probe hits: interval + 2 edges.

Test Plan:
- Reset mid-ISSUE:
  - Assert reset while control = 8'h04.
  - control = 0 and busy = 0 immediately, spawn_count = 0; after release the LFSR restarts from the seed.
- First spawn timing:
  - Setup: BASE_INTERVAL = 16, level = 0, hiding = 8'hFF, enable raised.
  - Control goes one-hot on the 18th edge after enable is sampled.
  - Model drops the matching hiding bit 2 cycles later -> control = 0 next edge, spawn_count = 1.
- Level scaling:
  - Setup: level = 3, BASE_INTERVAL = 16.
  - Interval is 2 cycles; first control on the 4th edge after enable.
- MAX_ACTIVE cap:
  - Setup: MAX_ACTIVE = 2, hiding = 8'b1111_1100.
  - control stays 0 indefinitely.
  - Release mole 0 (hiding = 8'b1111_1101) -> a spawn is issued on the next cycle's PICK path, targeting only a hiding mole.
- Probe wrap-around:
  - Setup: hiding = 8'b0000_0001, forced LFSR[2:0] = 5.
  - Probes 5, 6, 7, then 0 -> control = 8'h01 after 4 PICK cycles.
  - With hiding = 0 (and MAX_ACTIVE = 8): 8 probes, then return to WAIT, with no control and no timeout.
- Timeout:
  - Setup: ACK_TIMEOUT = 8, hiding never drops.
  - control is held 8 cycles, then clears; timeout pulses exactly 1 cycle; spawn_count is unchanged.
  - Ack arriving on the timeout cycle -> spawn_count increments and timeout stays 0.
